// File: rtl/param_delay_bank_if.sv
// Bundle for param_delay_bank: sample stream, delay configuration and delayed output.
// The beam_sum member exists only when PARAM_DELAY_BANK_SUM_EN is defined.
interface param_delay_bank_if #(
    parameter int N_CH    = 16,
    parameter int DW      = 19,
    parameter int MAX_DLY = 64,
    parameter int AW      = $clog2(MAX_DLY)
);
    logic                        sample_valid;
    logic [N_CH*DW-1:0]          pcm_in;
    logic                        cfg_we;
    logic [$clog2(N_CH)-1:0]     cfg_ch;
    logic [AW:0]                 cfg_delay;
    logic                        cfg_commit;
    logic                        commit_pending;
    logic [N_CH*DW-1:0]          pcm_out;
    logic                        out_valid;
`ifdef PARAM_DELAY_BANK_SUM_EN
    logic signed [DW+$clog2(N_CH)-1:0] beam_sum;

    modport master (
        output sample_valid, pcm_in, cfg_we, cfg_ch, cfg_delay, cfg_commit,
        input  commit_pending, pcm_out, out_valid, beam_sum
    );
    modport slave (
        input  sample_valid, pcm_in, cfg_we, cfg_ch, cfg_delay, cfg_commit,
        output commit_pending, pcm_out, out_valid, beam_sum
    );
`else
    modport master (
        output sample_valid, pcm_in, cfg_we, cfg_ch, cfg_delay, cfg_commit,
        input  commit_pending, pcm_out, out_valid
    );
    modport slave (
        input  sample_valid, pcm_in, cfg_we, cfg_ch, cfg_delay, cfg_commit,
        output commit_pending, pcm_out, out_valid
    );
`endif
endinterface

// File: rtl/param_delay_bank.sv
// Per-channel programmable sample delay bank for a microphone array.
// Each channel has a MAX_DLY-deep circular buffer sharing one write pointer;
// delays are staged in a shadow set and committed atomically on a sample strobe.
// Optional feature: define PARAM_DELAY_BANK_SUM_EN to add the registered beam_sum output.
module param_delay_bank #(
    parameter int N_CH    = 16,
    parameter int DW      = 19,
    parameter int MAX_DLY = 64,
    parameter int AW      = $clog2(MAX_DLY)
) (
    input  logic               clk,
    input  logic               rst_n,
    param_delay_bank_if.slave  bus
);
    localparam int CW = $clog2(N_CH);
`ifdef PARAM_DELAY_BANK_SUM_EN
    localparam int SW = DW + CW;
    logic signed [SW-1:0] sum_q, sum_d;
`endif

    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]          fill_q, fill_d;
    logic [AW-1:0]        act_q [N_CH];
    logic [AW-1:0]        act_d [N_CH];
    logic [AW-1:0]        shd_q [N_CH];
    logic [AW-1:0]        shd_d [N_CH];
    logic                 pend_q, pend_d;
    logic                 vld_q;
    logic [N_CH*DW-1:0]   out_q, out_d;
    logic [DW-1:0]        mem [N_CH][MAX_DLY];

    logic                 commit_now;
    logic                 ch_ok;
    logic [AW-1:0]        cfg_clamped;
    logic [AW-1:0]        rd_ptr;
    logic signed [DW-1:0] samp;

    // Next-state: shadow write, commit, pointer/fill advance and output selection.
    always_comb begin
        // MAX_DLY is a power of two, so any value above MAX_DLY-1 has its top bit set.
        cfg_clamped = bus.cfg_delay[AW] ? '1 : bus.cfg_delay[AW-1:0];
        ch_ok       = (32'(bus.cfg_ch) < N_CH);

        shd_d = shd_q;
        if (bus.cfg_we && ch_ok) begin
            shd_d[bus.cfg_ch] = cfg_clamped;
        end

        // A commit applied this cycle takes the shadow set including this cycle's write.
        commit_now = bus.sample_valid && (pend_q || bus.cfg_commit);
        if (commit_now) begin
            act_d = shd_d;
        end else begin
            act_d = act_q;
        end

        if (commit_now) begin
            pend_d = 1'b0;
        end else if (bus.cfg_commit) begin
            pend_d = 1'b1;
        end else begin
            pend_d = pend_q;
        end

        wr_ptr_d = bus.sample_valid ? wr_ptr_q + 1'b1 : wr_ptr_q;
        fill_d   = (bus.sample_valid && (fill_q != (AW+1)'(MAX_DLY))) ? fill_q + 1'b1 : fill_q;

        out_d  = out_q;
        rd_ptr = '0;
        samp   = '0;
`ifdef PARAM_DELAY_BANK_SUM_EN
        sum_d  = bus.sample_valid ? '0 : sum_q;
`endif
        for (int unsigned c = 0; c < N_CH; c++) begin
            rd_ptr = wr_ptr_q - act_d[c];
            if ({1'b0, act_d[c]} > fill_q) begin
                samp = '0;
            end else if (act_d[c] == '0) begin
                samp = bus.pcm_in[c*DW +: DW];
            end else begin
                samp = mem[c][rd_ptr];
            end
            if (bus.sample_valid) begin
                out_d[c*DW +: DW] = samp;
`ifdef PARAM_DELAY_BANK_SUM_EN
                sum_d = sum_d + SW'(samp);
`endif
            end
        end
    end

    // Control and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            fill_q   <= '0;
            pend_q   <= 1'b0;
            vld_q    <= 1'b0;
            out_q    <= '0;
            for (int unsigned c = 0; c < N_CH; c++) begin
                act_q[c] <= '0;
                shd_q[c] <= '0;
            end
`ifdef PARAM_DELAY_BANK_SUM_EN
            sum_q    <= '0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            pend_q   <= pend_d;
            vld_q    <= bus.sample_valid;
            out_q    <= out_d;
            act_q    <= act_d;
            shd_q    <= shd_d;
`ifdef PARAM_DELAY_BANK_SUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

    // Sample buffers: not reset, stale contents are masked by the fill count.
    always_ff @(posedge clk) begin
        if (bus.sample_valid) begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                mem[c][wr_ptr_q] <= bus.pcm_in[c*DW +: DW];
            end
        end
    end

    assign bus.commit_pending = pend_q;
    assign bus.out_valid      = vld_q;
    assign bus.pcm_out        = out_q;
`ifdef PARAM_DELAY_BANK_SUM_EN
    assign bus.beam_sum       = sum_q;
`endif
endmodule
